// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide path.
// The decode helper maps an R-type funct field to the controller opcode.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NONE  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

  localparam int         DIV_LAT  = 32;
  localparam logic [5:0] OP_RTYPE = 6'h00;

  function automatic muldiv_op_t decode_muldiv(input logic [5:0] opcode, input logic [5:0] funct);
    muldiv_op_t r;
    r = MD_NONE;
    if (opcode == OP_RTYPE) begin
      case (funct)
        6'h18:   r = MD_MULT;
        6'h19:   r = MD_MULTU;
        6'h1A:   r = MD_DIV;
        6'h1B:   r = MD_DIVU;
        6'h11:   r = MD_MTHI;
        6'h13:   r = MD_MTLO;
        default: r = MD_NONE;
      endcase
    end else begin
      r = MD_NONE;
    end
    return r;
  endfunction

  function automatic logic is_muldiv(input muldiv_op_t op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle after load.
// quo/rem present the result of the step taken at the coming edge.
module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [32:0] shifted_s, diff_s;
  logic [31:0] step_rem_s, step_quo_s;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    shifted_s = {rem_q, quo_q[31]};
    diff_s    = shifted_s - {1'b0, dvs_q};
    if (!diff_s[32]) begin
      step_rem_s = diff_s[31:0];
      step_quo_s = {quo_q[30:0], 1'b1};
    end else begin
      step_rem_s = shifted_s[31:0];
      step_quo_s = {quo_q[30:0], 1'b0};
    end
    if (load) begin
      rem_d = 32'd0;
      quo_d = dividend;
      dvs_d = divisor;
    end else begin
      rem_d = step_rem_s;
      quo_d = step_quo_s;
      dvs_d = dvs_q;
    end
  end

  assign quo = step_quo_s;
  assign rem = step_rem_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= 32'd0;
      quo_q <= 32'd0;
      dvs_q <= 32'd0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller: sequences multiply and iterative divide,
// owns HI/LO, and stalls Execute until the result is committed.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  md_state_t   state_q, state_d;
  muldiv_op_t  op_q, op_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        div_load_s;
  logic [31:0] div_dvd_s, div_dvs_s, div_quo_s, div_rem_s;
  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic [31:0] quo_fix_s, rem_fix_s, res_hi_s, res_lo_s;

  // Divider sees magnitudes; the sign fix-up happens on the way out.
  always_comb begin
    div_load_s = (state_q == S_IDLE) && start && !flush && is_div(op);
    div_dvd_s  = ((op == MD_DIV) && a[31]) ? (32'd0 - a) : a;
    div_dvs_s  = ((op == MD_DIV) && b[31]) ? (32'd0 - b) : b;
  end

  div_iter u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load_s),
    .dividend (div_dvd_s),
    .divisor  (div_dvs_s),
    .quo      (div_quo_s),
    .rem      (div_rem_s)
  );

  // Result selection for the committing BUSY cycle.
  always_comb begin
    mul_a_s   = {{32{(op_q == MD_MULT) & a_q[31]}}, a_q};
    mul_b_s   = {{32{(op_q == MD_MULT) & b_q[31]}}, b_q};
    prod_s    = mul_a_s * mul_b_s;
    quo_fix_s = ((op_q == MD_DIV) && (a_q[31] ^ b_q[31])) ? (32'd0 - div_quo_s) : div_quo_s;
    rem_fix_s = ((op_q == MD_DIV) && a_q[31]) ? (32'd0 - div_rem_s) : div_rem_s;
    if (!is_div(op_q)) begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end else if (b_q == 32'd0) begin
      res_hi_s = a_q;
      res_lo_s = 32'hFFFF_FFFF;
    end else begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_fix_s;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end else if (is_muldiv(op)) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            cnt_d   = is_div(op) ? DIV_CNT : MUL_CNT;
            state_d = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush) begin
          cnt_d   = 6'd0;
          state_d = S_IDLE;
        end else if (cnt_q == 6'd0) begin
          hi_d    = res_hi_s;
          lo_d    = res_lo_s;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_BUSY);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= MD_NONE;
      cnt_q   <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stall = !flush && (((state_q == S_IDLE) && start && is_muldiv(op)) || (state_q == S_BUSY));
  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MUL_LAT = 2).
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  muldiv_op_t  op;
  logic [31:0] a, b;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Issue one op from IDLE, hold start until done; returns stall count and done cycle.
  task automatic do_op(input muldiv_op_t o, input logic [31:0] xa, input logic [31:0] xb,
                       output int stalls, output int done_at);
    stalls  = 0;
    done_at = -1;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = xa; b = xb;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (stall) stalls++;
      if (done) begin
        done_at = i;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = MD_NONE; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    #3 reset = 1'b0;
  endtask

  task automatic test_mult();
    int s, d;
    do_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, s, d);
    checks++; if (s !== 3) begin errors++; $display("FAIL mult_stalls got %0d exp 3", s); end
    checks++; if (d !== 3) begin errors++; $display("FAIL mult_done_cycle got %0d exp 3", d); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", lo); end
    @(posedge clk); #2;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mult_after_done done %b busy %b exp 0 0", done, busy); end
    do_op(MD_MULTU, 32'hFFFF_FFFD, 32'd5, s, d);
    checks++; if (hi !== 32'h0000_0004) begin errors++; $display("FAIL multu_hi got %h exp 00000004", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL multu_lo got %h exp fffffff1", lo); end
  endtask

  task automatic test_div();
    int s, d;
    do_op(MD_DIVU, 32'd100, 32'd7, s, d);
    checks++; if (s !== 33) begin errors++; $display("FAIL divu_stalls got %0d exp 33", s); end
    checks++; if (d !== 33) begin errors++; $display("FAIL divu_done_cycle got %0d exp 33", d); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h exp 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h exp 00000002", hi); end
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, s, d);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h exp ffffffff", hi); end
    do_op(MD_DIV, 32'd100, 32'hFFFF_FFF9, s, d);
    checks++; if (lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_negb_lo got %h exp fffffff2", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_negb_hi got %h exp 00000002", hi); end
  endtask

  task automatic test_div_zero();
    int s, d;
    do_op(MD_DIVU, 32'h0000_1234, 32'd0, s, d);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got %h exp ffffffff", lo); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL divu0_hi got %h exp 00001234", hi); end
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s, d);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h exp 00000000", hi); end
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, s, d);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h exp ffffffff", lo); end
    checks++; if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div0_hi got %h exp fffffff9", hi); end
  endtask

  task automatic test_flush();
    logic saw_done;
    saw_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    flush = 1'b1; start = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b exp 1", busy); end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b exp 0", busy); end
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #2;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_done_pulse got %b exp 0", saw_done); end
    checks++; if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL flush_hi got %h exp fffffff9", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL flush_lo got %h exp ffffffff", lo); end
    @(posedge clk); #1;
    start = 1'b1; op = MD_MTHI; a = 32'h0000_DEAD; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    checks++; if (hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL flush_mthi_hi got %h exp fffffff9", hi); end
  endtask

  task automatic test_back_to_back();
    int s, d;
    @(posedge clk); #1;
    start = 1'b1; op = MD_MTHI; a = 32'h0000_AAAA;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got %b exp 0", stall); end
    @(posedge clk); #1;
    op = MD_MTLO; a = 32'h0000_5555;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mtlo_stall got %b exp 0", stall); end
    checks++; if (hi !== 32'h0000_AAAA) begin errors++; $display("FAIL mthi_value got %h exp 0000aaaa", hi); end
    @(posedge clk); #1;
    op = MD_MULTU; a = 32'h0001_0000; b = 32'h0001_0000;
    #1;
    checks++; if (lo !== 32'h0000_5555) begin errors++; $display("FAIL mtlo_value got %h exp 00005555", lo); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_accept_stall got %b exp 1", stall); end
    repeat (3) @(posedge clk);
    #2;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", done); end
    checks++; if (hi !== 32'd1 || lo !== 32'd0) begin errors++; $display("FAIL b2b_result got %h_%h exp 00000001_00000000", hi, lo); end
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_retrigger busy got %b exp 0", busy); end
    do_op(MD_MULT, 32'd6, 32'd7, s, d);
    do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, s, d);
    checks++; if (s !== 3) begin errors++; $display("FAIL b2b_second_stalls got %0d exp 3", s); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL b2b_second_result got %h_%h exp ffffffff_fffffffa", hi, lo); end
  endtask

  task automatic test_reset_mid();
    int s, d;
    @(posedge clk); #1;
    start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd3;
    @(posedge clk); #3;
    reset = 1'b1; start = 1'b0;
    #1;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL areset_hilo got %h_%h exp 0_0", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL areset_stall got %b exp 0", stall); end
    @(posedge clk); #3;
    reset = 1'b0;
    do_op(MD_MULT, 32'd3, 32'd3, s, d);
    checks++; if (s !== 3) begin errors++; $display("FAIL post_reset_stalls got %0d exp 3", s); end
    checks++; if (hi !== 32'd0 || lo !== 32'd9) begin errors++; $display("FAIL post_reset_result got %h_%h exp 0_9", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
